// File: rtl/parking_alert_pkg.sv
// -----------------------------------------------------------------------------
// parking_alert_pkg
// Shared definitions for the parking-lot alert scheduler:
//   state_t       - scheduler FSM states (IDLE, BURST, GAP)
//   TOG_W         - width of one per-source toggle-count field
//   MAX_SRC       - upper bound on requesters supported by toggle_field()
//   toggle_field  - extracts the 4-bit half-period count for one source from
//                   the packed toggle table (source 0 in the LSBs)
// -----------------------------------------------------------------------------
package parking_alert_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned TOG_W   = 4;
    localparam int unsigned MAX_SRC = 16;

    function automatic logic [TOG_W-1:0] toggle_field(
        input logic [MAX_SRC*TOG_W-1:0] toggles,
        input int unsigned              idx
    );
        return toggles[idx*TOG_W +: TOG_W];
    endfunction

endpackage

// File: rtl/parking_alert_scheduler_burst_gen.sv
// -----------------------------------------------------------------------------
// alert_burst_gen
// Plays one burst of `len` half-periods, each HALF_PERIOD cycles long.
// The output is high in even phases and low in odd phases, so an odd length
// always ends on a high phase.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   start - launch a burst (output goes high on the next cycle)
//   stop  - synchronous abort; clears the output and both counters
//   len   - half-periods in the burst, sampled on start (1..15)
//   out   - registered burst waveform
//   done  - high in the final cycle of the last phase
// -----------------------------------------------------------------------------
module alert_burst_gen
    import parking_alert_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 250,
    parameter int unsigned CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [TOG_W-1:0] len,
    output logic             out,
    output logic             done
);

    localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [TOG_W-1:0] k;
    logic [TOG_W-1:0] len_q;
    logic             running;
    logic [TOG_W:0]   k_inc;
    logic             phase_end;
    logic             last_phase;

    assign k_inc      = {1'b0, k} + {{TOG_W{1'b0}}, 1'b1};
    assign phase_end  = running && (cnt == HP_LAST);
    // A zero length is treated as a single phase rather than wrapping k.
    assign last_phase = (k_inc >= {1'b0, len_q});
    // Combinational so the scheduler leaves BURST on the same edge the
    // waveform drops, keeping the burst exactly len*HALF_PERIOD cycles.
    assign done       = phase_end && last_phase;

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            cnt     <= '0;
            k       <= '0;
            len_q   <= '0;
            running <= 1'b0;
            out     <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            k       <= '0;
            len_q   <= len;
            running <= 1'b1;
            out     <= 1'b1;
        end else if (running) begin
            if (phase_end) begin
                cnt <= '0;
                if (last_phase) begin
                    k       <= '0;
                    running <= 1'b0;
                    out     <= 1'b0;
                end else begin
                    k   <= k_inc[TOG_W-1:0];
                    out <= ~out;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_alert_scheduler.sv
// -----------------------------------------------------------------------------
// parking_alert_scheduler
// Shares one alert pin between NUM_SRC requesters. Requests are latched as
// pending, a fixed-priority arbiter (index 0 highest) grants one source at a
// time, its burst pattern is played, and a quiet gap follows every burst.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   req        - level requests; any high cycle sets the matching pending bit
//   mute       - synchronous abort; silences output and clears all pending
//   out_signal - alert pin
//   busy       - high while in BURST or GAP
//   active_src - one-hot source being played, zero outside BURST
//   pending    - latched requests not yet granted
// -----------------------------------------------------------------------------
module parking_alert_scheduler
    import parking_alert_pkg::*;
#(
    parameter int unsigned               NUM_SRC     = 3,
    parameter int unsigned               HALF_PERIOD = 250,
    parameter int unsigned               GAP_CYCLES  = 500,
    parameter logic [NUM_SRC*TOG_W-1:0]  SRC_TOGGLES = {4'd7, 4'd3, 4'd5},
    parameter int unsigned               CNT_W       = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               mute,
    output logic               out_signal,
    output logic               busy,
    output logic [NUM_SRC-1:0] active_src,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [MAX_SRC*TOG_W-1:0] TOG_TABLE = (MAX_SRC*TOG_W)'(SRC_TOGGLES);
    localparam logic [CNT_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t             state;
    logic [CNT_W-1:0]   gap_cnt;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] grant_mask;
    int unsigned        grant_idx;
    logic               grant_found;
    logic               start;
    logic [TOG_W-1:0]   grant_len;
    logic               burst_done;
    logic               burst_out;

    // Fixed priority: lowest set index wins.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = 0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && !grant_found) begin
                grant_oh[i] = 1'b1;
                grant_idx   = i;
                grant_found = 1'b1;
            end
        end
    end

    assign start      = (state == IDLE) && grant_found && !mute;
    assign grant_mask = start ? grant_oh : '0;
    assign grant_len  = toggle_field(TOG_TABLE, grant_idx);
    assign out_signal = burst_out;

    alert_burst_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_burst_gen (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (mute),
        .len   (grant_len),
        .out   (burst_out),
        .done  (burst_done)
    );

    always_ff @(posedge clk) begin
        if (rst || mute) begin
            state      <= IDLE;
            pending    <= '0;
            active_src <= '0;
            busy       <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            // Clear the granted bit before OR-ing in req, so a request in the
            // grant cycle (including from the granted source) is kept.
            pending <= (pending & ~grant_mask) | req;

            case (state)
                IDLE: begin
                    if (start) begin
                        active_src <= grant_oh;
                        busy       <= 1'b1;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (burst_done) begin
                        active_src <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_alert_scheduler.sv
// -----------------------------------------------------------------------------
// tb_parking_alert_scheduler
// Scoreboard bench: each scenario records the bursts it should produce, the
// expected per-cycle out_signal/busy/active_src values are queued from that
// burst list, and a negedge monitor pops and compares entries as the
// scenario-relative cycle counter reaches them.
// -----------------------------------------------------------------------------
module tb_parking_alert_scheduler;

    localparam int         HP   = 4;
    localparam int         GAPC = 3;
    localparam int         BIG  = 1 << 30;
    localparam logic [11:0] TOGS = {4'd7, 4'd3, 4'd5};

    logic       clk = 1'b0;
    logic       rst;
    logic       mute;
    logic [2:0] req;
    logic       out_signal;
    logic       busy;
    logic [2:0] active_src;
    logic [2:0] pending;

    always #5 clk = ~clk;

    parking_alert_scheduler #(
        .NUM_SRC     (3),
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAPC),
        .SRC_TOGGLES (TOGS),
        .CNT_W       (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mute       (mute),
        .out_signal (out_signal),
        .busy       (busy),
        .active_src (active_src),
        .pending    (pending)
    );

    typedef struct {
        int start;
        int tog;
        int src;
        int stop;
    } burst_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    burst_t bursts[$];
    exp_t   sb[$];
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     mon_en   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    function automatic logic in_phase_window(input burst_t b, input int t);
        return (t >= b.start) && (t < b.start + b.tog * HP) && (t <= b.stop);
    endfunction

    function automatic logic exp_out(input int t);
        foreach (bursts[i]) begin
            if (in_phase_window(bursts[i], t) && (((t - bursts[i].start) / HP) % 2 == 0))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (bursts[i]) begin
            if ((t >= bursts[i].start) && (t < bursts[i].start + bursts[i].tog * HP + GAPC)
                && (t <= bursts[i].stop))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_act(input int t);
        foreach (bursts[i]) begin
            if (in_phase_window(bursts[i], t))
                return 3'(1 << bursts[i].src);
        end
        return 3'b000;
    endfunction

    function automatic logic [31:0] observed(input int kind);
        case (kind)
            0:       return 32'(out_signal);
            1:       return 32'(busy);
            2:       return 32'(active_src);
            default: return 32'(pending);
        endcase
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            0:       return "out_signal";
            1:       return "busy";
            2:       return "active_src";
            default: return "pending";
        endcase
    endfunction

    task automatic push_window(input int from, input int to);
        for (int t = from; t <= to; t++) begin
            sb.push_back('{t, 0, 32'(exp_out(t))});
            sb.push_back('{t, 1, 32'(exp_busy(t))});
            sb.push_back('{t, 2, 32'(exp_act(t))});
        end
    endtask

    task automatic push_pend(input int t, input logic [2:0] v);
        sb.push_back('{t, 3, 32'(v)});
    endtask

    always @(negedge clk) begin
        exp_t keep[$];
        if (mon_en) begin
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].cyc <= cyc)
                    check_val($sformatf("%s@c%0d", kind_name(sb[i].kind), sb[i].cyc),
                              observed(sb[i].kind), sb[i].val);
                else
                    keep.push_back(sb[i]);
            end
            sb = keep;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_req(input int n, input logic [2:0] mask);
        run_to(n);
        req = mask;
        tick();
        req = '0;
    endtask

    task automatic start_scn();
        mon_en = 1'b0;
        req    = '0;
        mute   = 1'b0;
        rst    = 1'b1;
        bursts = {};
        sb     = {};
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 0;
        mon_en = 1'b1;
    endtask

    task automatic finish_scn(input int last, input string name);
        run_to(last + 1);
        check_val({name, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        mute = 1'b0;
        req  = '0;

        // Single request from src0: H,L,H,L,H then gap, busy low from 35.
        start_scn();
        bursts.push_back('{12, 5, 0, BIG});
        push_window(0, 40);
        push_pend(11, 3'b001);
        push_pend(12, 3'b000);
        pulse_req(10, 3'b001);
        finish_scn(40, "single");

        // Priority: src1 before src2, src2 rises at 28.
        start_scn();
        bursts.push_back('{12, 3, 1, BIG});
        bursts.push_back('{28, 7, 2, BIG});
        push_window(0, 62);
        push_pend(11, 3'b110);
        push_pend(12, 3'b100);
        push_pend(27, 3'b100);
        push_pend(28, 3'b000);
        pulse_req(10, 3'b110);
        finish_scn(62, "priority");

        // Coalescing: req[1] held 20 cycles during src0 -> one src1 burst.
        start_scn();
        bursts.push_back('{12, 5, 0, BIG});
        bursts.push_back('{36, 3, 1, BIG});
        push_window(0, 60);
        push_pend(20, 3'b010);
        push_pend(35, 3'b010);
        for (int t = 36; t <= 60; t++) push_pend(t, 3'b000);
        pulse_req(10, 3'b001);
        run_to(14);
        req = 3'b010;
        repeat (20) tick();
        req = '0;
        finish_scn(60, "coalesce");

        // Mute mid-burst with src2 pending and a same-cycle req[1].
        start_scn();
        bursts.push_back('{12, 5, 0, 18});
        push_window(0, 45);
        push_pend(13, 3'b100);
        for (int t = 19; t <= 45; t++) push_pend(t, 3'b000);
        pulse_req(10, 3'b001);
        pulse_req(12, 3'b100);
        run_to(18);
        mute = 1'b1;
        req  = 3'b010;
        tick();
        mute = 1'b0;
        req  = '0;
        finish_scn(45, "mute");

        // Reset during the gap, then a fresh request served at c+2.
        start_scn();
        bursts.push_back('{12, 5, 0, 33});
        bursts.push_back('{38, 5, 0, BIG});
        push_window(0, 65);
        push_pend(34, 3'b000);
        push_pend(37, 3'b001);
        push_pend(38, 3'b000);
        pulse_req(10, 3'b001);
        run_to(33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_req(36, 3'b001);
        finish_scn(65, "reset_gap");

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_alert_scheduler.md
# parking_alert_scheduler

Shares the single parking-lot alert output (buzzer/LED) between several alert requesters: lot full, entry denied, gate fault. Each request is latched as pending, and a fixed-priority arbiter grants one source at a time. The granted source's burst pattern (a count of half-periods) is then played on the output. A mandatory quiet gap follows every burst. The block sits between the occupancy/gate control logic and the alert pin, and replaces per-source toggle generators driving the pin directly.

## Interface
- NUM_SRC, 3, number of requesters; index 0 is highest priority
- HALF_PERIOD, 250, clock cycles per half-period of a burst (≥1)
- GAP_CYCLES, 500, quiet cycles after every burst (≥0)
- SRC_TOGGLES, {4'd7,4'd3,4'd5}, packed NUM_SRC×4 bits; half-periods per burst for each source, src0 in the LSBs, each value 1..15
- CNT_W, 26, half-period/gap counter width
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_SRC  level requests; any cycle high sets pending[i]
- mute  in  1  synchronous abort: silences output and clears all pending
- out_signal  out  1  alert pin
- busy  out  1  high in BURST or GAP
- active_src  out  NUM_SRC  one-hot source being played; 0 when not in BURST
- pending  out  NUM_SRC  latched, not-yet-granted requests

## Operation
- States: IDLE, BURST, GAP. Reset puts the block in IDLE with every output and internal register at 0.
- Pending: set when req[i]=1. Cleared only by a grant of source i, or by mute. A request repeated while source i is pending coalesces into one. A request from the source currently playing sets pending again, so that source plays again later.
- IDLE: if pending≠0, grant the lowest set index i:
  - clear pending[i], set active_src to bit i, out_signal<=1
  - reset half-period counter cnt=0 and phase k=0; go to BURST
- BURST: cnt counts 0..HALF_PERIOD-1. At the terminal count:
  - if k<SRC_TOGGLES[i]-1: k<=k+1, toggle out_signal, cnt<=0
  - else: out_signal<=0, active_src<=0, go to GAP (or to IDLE if GAP_CYCLES=0)
  - Resulting pattern: high in even phases, low in odd phases. Toggles=5 gives H,L,H,L,H.
- GAP: out_signal=0 for GAP_CYCLES cycles, then IDLE.
- No preemption. A higher-priority request waits for the current burst and its gap to finish.
- mute=1 has priority over all other behaviour:
  - next state IDLE; out_signal, active_src, cnt, k cleared
  - pending cleared, including a req asserted in the same cycle
- rst overrides mute.

## Timing
- req high in cycle c → pending visible in c+1 → out_signal high from c+2, provided the block is IDLE.
- Burst length is SRC_TOGGLES[i]×HALF_PERIOD cycles. Each phase lasts exactly HALF_PERIOD cycles.
- Back-to-back bursts have GAP_CYCLES+1 low cycles between the last high phase and the next rise (gap plus one IDLE arbitration cycle). The odd-toggle count guarantees the final phase is high.
- busy rises together with the first out_signal high. It falls in the IDLE cycle that follows the gap.
- req arriving in the same cycle as a grant: it is recorded in pending and does not affect the current grant.
- Counter wrap: cnt never exceeds HALF_PERIOD-1 or GAP_CYCLES-1. HALF_PERIOD and GAP_CYCLES must fit in CNT_W bits.

## Structure
- Shared package parking_alert_pkg holds:
  - the state enum {IDLE, BURST, GAP}
  - the TOG_W=4 constant
  - a helper function that extracts the 4-bit toggle field for a source
- One sub-module, alert_burst_gen, is natural. Ports: start, len[3:0], out, done. It contains the cnt and k counters, parameterised by HALF_PERIOD. The scheduler keeps the pending register, the arbiter, the gap counter and the FSM.

## Test plan
- Bench settings: HALF_PERIOD=4, GAP_CYCLES=3, SRC_TOGGLES={7,3,5}.
- Single request: req[0] high for 1 cycle at c=10. Required response:
  - out_signal high cycles 12–15, low 16–19, high 20–23, low 24–27, high 28–31
  - busy low from cycle 35
- Priority: req[2] and req[1] both pulsed at cycle 10. Required response:
  - src1 plays first: 3 phases, cycles 12–23
  - gap 24–26, IDLE at 27
  - src2 rises at 28 and plays 7 phases, ending at 55
- Coalescing: req[1] held high for 20 cycles while src0 is playing. Required response: exactly one src1 burst after src0's gap, and pending[1] is 0 afterwards.
- Mute mid-burst: mute pulsed at cycle 18 during src0's burst, with req[2] pending. Required response: out_signal=0 and pending=0 from cycle 19; no further bursts.
- Reset mid-gap: rst asserted in GAP. Required response: all outputs 0 on the next cycle, state IDLE; a new req[0] is served with the normal c+2 latency.
